// File: rtl/gb_reg_bank.sv
// Byte register bank with pair access, pair stepping, shadow context swap and masked flag register.
// Optional feature: define REG_BANK_BYPASS_EN to forward the resolved next-state value to the read ports.
module gb_reg_bank #(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD = 3,
    parameter int FLAG_IDX = 7,
    parameter logic [DATA_W-1:0] FLAG_MASK = 8'hF0,
    localparam int SEL_W = $clog2(NUM_REGS),
    localparam int PR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD*SEL_W-1:0]    i_rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    input  logic [PR_W-1:0]            i_pr_sel,
    output logic [2*DATA_W-1:0]        o_pr_data,
    input  logic                       i_wr_en,
    input  logic [SEL_W-1:0]           i_wr_sel,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_pw_en,
    input  logic [PR_W-1:0]            i_pw_sel,
    input  logic [2*DATA_W-1:0]        i_pw_data,
    input  logic                       i_id_en,
    input  logic [PR_W-1:0]            i_id_sel,
    input  logic                       i_id_dec,
    input  logic                       i_save,
    input  logic                       i_restore,
    output logic                       o_shadow_valid,
    output logic                       o_wr_conflict
);

    localparam int NUM_PAIRS = NUM_REGS / 2;
    localparam logic [2*DATA_W-1:0] PAIR_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs_s     [NUM_REGS];
    logic [DATA_W-1:0]   next_s     [NUM_REGS];
    logic [DATA_W-1:0]   rd_src_s   [NUM_REGS];
    logic [2*DATA_W-1:0] pair_s     [NUM_PAIRS];
    logic [2*DATA_W-1:0] pair_src_s [NUM_PAIRS];
    logic [2*DATA_W-1:0] id_pair_s;
    logic [2*DATA_W-1:0] id_step_s;
    logic [NUM_REGS-1:0] hi_win_s;
    logic                restore_act_s;
    logic                conflict_s;
    logic                shadow_valid_r;
    logic                wr_conflict_r;

    // Unwritable flag bits are forced to zero on every write path.
    function automatic logic [DATA_W-1:0] flag_filter(input int idx, input logic [DATA_W-1:0] val);
        if (idx == FLAG_IDX) begin
            return val & FLAG_MASK;
        end else begin
            return val;
        end
    endfunction

    assign restore_act_s = i_restore & shadow_valid_r;
    assign id_pair_s     = pair_s[i_id_sel];
    assign id_step_s     = i_id_dec ? (id_pair_s - PAIR_ONE) : (id_pair_s + PAIR_ONE);
    assign conflict_s    = i_wr_en & hi_win_s[i_wr_sel];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam int  P  = i / 2;
        localparam bit  HI = ((i % 2) == 0);

        logic [DATA_W-1:0] data_r;
        logic [DATA_W-1:0] shadow_byte_r;
        logic [DATA_W-1:0] raw_s;
        logic [DATA_W-1:0] pw_byte_s;
        logic [DATA_W-1:0] id_byte_s;
        logic              pw_hit_s;
        logic              id_hit_s;
        logic              wr_hit_s;

        assign pw_hit_s  = i_pw_en & (i_pw_sel == PR_W'(P));
        assign id_hit_s  = i_id_en & (i_id_sel == PR_W'(P));
        assign wr_hit_s  = i_wr_en & (i_wr_sel == SEL_W'(i));
        assign pw_byte_s = HI ? i_pw_data[DATA_W +: DATA_W] : i_pw_data[0 +: DATA_W];
        assign id_byte_s = HI ? id_step_s[DATA_W +: DATA_W] : id_step_s[0 +: DATA_W];

        // Fixed-priority next-state resolution for this byte.
        always_comb begin
            if (restore_act_s) begin
                raw_s = shadow_byte_r;
            end else if (pw_hit_s) begin
                raw_s = pw_byte_s;
            end else if (id_hit_s) begin
                raw_s = id_byte_s;
            end else if (wr_hit_s) begin
                raw_s = i_wr_data;
            end else begin
                raw_s = data_r;
            end
        end

        assign next_s[i]   = flag_filter(i, raw_s);
        assign hi_win_s[i] = restore_act_s | pw_hit_s | id_hit_s;
        assign regs_s[i]   = data_r;

`ifdef REG_BANK_BYPASS_EN
        // Forwarding path is gated so reset still reads back zero with requests pending.
        assign rd_src_s[i] = i_rst_n ? next_s[i] : {DATA_W{1'b0}};
`else
        assign rd_src_s[i] = data_r;
`endif

        // Register byte and its shadow; the shadow captures the pre-edge value, giving an atomic swap.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data_r        <= {DATA_W{1'b0}};
                shadow_byte_r <= {DATA_W{1'b0}};
            end else begin
                data_r <= next_s[i];
                if (i_save) begin
                    shadow_byte_r <= data_r;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        assign pair_s[p]     = {regs_s[2*p], regs_s[2*p+1]};
        assign pair_src_s[p] = {rd_src_s[2*p], rd_src_s[2*p+1]};
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign o_rd_data[k*DATA_W +: DATA_W] = rd_src_s[i_rd_sel[k*SEL_W +: SEL_W]];
    end

    assign o_pr_data = pair_src_s[i_pr_sel];

    // Shadow-valid flag and the one-cycle lost-byte-write pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_valid_r <= 1'b0;
            wr_conflict_r  <= 1'b0;
        end else begin
            if (i_save) begin
                shadow_valid_r <= 1'b1;
            end
            wr_conflict_r <= conflict_s;
        end
    end

    assign o_shadow_valid = shadow_valid_r;
    assign o_wr_conflict  = wr_conflict_r;

endmodule

// File: tb/tb_gb_reg_bank.sv
// Self-checking bench for gb_reg_bank: directed scenarios plus randomized traffic against a reference model.
module tb_gb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  rd_sel;
    logic [23:0] rd_data;
    logic [1:0]  pr_sel;
    logic [15:0] pr_data;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        pw_en;
    logic [1:0]  pw_sel;
    logic [15:0] pw_data;
    logic        id_en;
    logic [1:0]  id_sel;
    logic        id_dec;
    logic        save;
    logic        restore;
    logic        shadow_valid;
    logic        wr_conflict;

    int total = 0;
    int bad = 0;
    int m_reg [8];
    int m_sh  [8];
    bit m_valid;
    bit m_conf;

    always #10 clk = ~clk;

    gb_reg_bank dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_sel(rd_sel), .o_rd_data(rd_data),
        .i_pr_sel(pr_sel), .o_pr_data(pr_data),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
        .i_pw_en(pw_en), .i_pw_sel(pw_sel), .i_pw_data(pw_data),
        .i_id_en(id_en), .i_id_sel(id_sel), .i_id_dec(id_dec),
        .i_save(save), .i_restore(restore),
        .o_shadow_valid(shadow_valid), .o_wr_conflict(wr_conflict)
    );

    task automatic idle();
        wr_en = 1'b0; pw_en = 1'b0; id_en = 1'b0; save = 1'b0; restore = 1'b0;
        wr_sel = 3'd0; wr_data = 8'd0; pw_sel = 2'd0; pw_data = 16'd0; id_sel = 2'd0; id_dec = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 0;
            m_sh[i] = 0;
        end
        m_valid = 1'b0;
        m_conf = 1'b0;
    endtask

    // Apply lowest priority first so higher-priority sources overwrite it.
    task automatic model_edge();
        int nxt [8];
        int v;
        bit rs;
        rs = restore && m_valid;
        nxt = m_reg;
        if (wr_en) nxt[wr_sel] = int'(wr_data);
        if (id_en) begin
            v = m_reg[2*id_sel] * 256 + m_reg[2*id_sel+1];
            v = id_dec ? (v + 65535) % 65536 : (v + 1) % 65536;
            nxt[2*id_sel] = v / 256;
            nxt[2*id_sel+1] = v % 256;
        end
        if (pw_en) begin
            nxt[2*pw_sel] = int'(pw_data) / 256;
            nxt[2*pw_sel+1] = int'(pw_data) % 256;
        end
        if (rs) nxt = m_sh;
        nxt[7] = nxt[7] & 32'hF0;
        m_conf = wr_en && (rs || (pw_en && int'(pw_sel) == int'(wr_sel) / 2)
                              || (id_en && int'(id_sel) == int'(wr_sel) / 2));
        if (save) begin
            m_sh = m_reg;
            m_valid = 1'b1;
        end
        m_reg = nxt;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic read_reg(input int idx, output int val);
        int k;
        k = idx % 3;
        rd_sel[k*3 +: 3] = 3'(idx);
        #1;
        val = int'(rd_data[k*8 +: 8]);
    endtask

    task automatic read_pair(input int p, output int val);
        pr_sel = 2'(p);
        #1;
        val = int'(pr_data);
    endtask

    task automatic test_reset();
        int v;
        rst_n = 1'b0;
        idle();
        rd_sel = 9'd0;
        pr_sel = 2'd0;
        model_reset();
        #25;
        total++;
        if (shadow_valid !== 1'b0) begin bad++; $display("FAIL reset_shadow_valid got=%b exp=0", shadow_valid); end
        total++;
        if (wr_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", wr_conflict); end
        for (int i = 0; i < 8; i++) begin
            read_reg(i, v);
            total++;
            if (v !== 0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", i, v); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_timing();
        int v;
        int exp_now;
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h3C;
`ifdef REG_BANK_BYPASS_EN
        exp_now = 32'h3C;
`else
        exp_now = m_reg[2];
`endif
        read_reg(2, v);
        total++;
        if (v !== exp_now) begin bad++; $display("FAIL read_same_cycle got=%h exp=%h", v, exp_now); end
        cycle();
        read_reg(2, v);
        total++;
        if (v !== 32'h3C) begin bad++; $display("FAIL read_next_cycle got=%h exp=3c", v); end
    endtask

    task automatic test_incdec();
        int v;
        pw_en = 1'b1; pw_sel = 2'd2; pw_data = 16'h8000;
        cycle();
        for (int n = 0; n < 3; n++) begin
            id_en = 1'b1; id_sel = 2'd2; id_dec = 1'b1;
            cycle();
        end
        read_pair(2, v);
        total++;
        if (v !== 32'h7FFD) begin bad++; $display("FAIL dec3 got=%h exp=7ffd", v); end
        pw_en = 1'b1; pw_sel = 2'd1; pw_data = 16'h0000;
        cycle();
        id_en = 1'b1; id_sel = 2'd1; id_dec = 1'b1;
        cycle();
        read_pair(1, v);
        total++;
        if (v !== 32'hFFFF) begin bad++; $display("FAIL dec_wrap got=%h exp=ffff", v); end
        id_en = 1'b1; id_sel = 2'd1; id_dec = 1'b0;
        cycle();
        read_pair(1, v);
        total++;
        if (v !== 32'h0000) begin bad++; $display("FAIL inc_wrap got=%h exp=0000", v); end
    endtask

    task automatic test_conflict();
        int v;
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h11;
        pw_en = 1'b1; pw_sel = 2'd2; pw_data = 16'hABCD;
        cycle();
        total++;
        if (wr_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set got=%b exp=1", wr_conflict); end
        read_reg(4, v);
        total++;
        if (v !== 32'hAB) begin bad++; $display("FAIL conflict_reg4 got=%h exp=ab", v); end
        read_reg(5, v);
        total++;
        if (v !== 32'hCD) begin bad++; $display("FAIL conflict_reg5 got=%h exp=cd", v); end
        cycle();
        total++;
        if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_clear got=%b exp=0", wr_conflict); end
    endtask

    task automatic test_flag();
        int v;
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'hFF;
        cycle();
        read_reg(7, v);
        total++;
        if (v !== 32'hF0) begin bad++; $display("FAIL flag_byte got=%h exp=f0", v); end
        pw_en = 1'b1; pw_sel = 2'd3; pw_data = 16'h12FF;
        cycle();
        read_reg(7, v);
        total++;
        if (v !== 32'hF0) begin bad++; $display("FAIL flag_pair got=%h exp=f0", v); end
        read_reg(6, v);
        total++;
        if (v !== 32'h12) begin bad++; $display("FAIL flag_pair_hi got=%h exp=12", v); end
    endtask

    task automatic test_save_restore();
        int v;
        int e;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'(32'h10 + i);
            cycle();
        end
        save = 1'b1;
        cycle();
        total++;
        if (shadow_valid !== 1'b1) begin bad++; $display("FAIL save_valid got=%b exp=1", shadow_valid); end
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'h00;
            cycle();
        end
        restore = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            e = (i == 7) ? 32'h10 : 32'h10 + i;
            read_reg(i, v);
            total++;
            if (v !== e) begin bad++; $display("FAIL restore_reg%0d got=%h exp=%h", i, v, e); end
        end
    endtask

    task automatic test_swap();
        int v;
        int e;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'(32'h20 + i);
            cycle();
        end
        save = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'(32'h40 + i);
            cycle();
        end
        save = 1'b1; restore = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            e = (i == 7) ? 32'h20 : 32'h20 + i;
            read_reg(i, v);
            total++;
            if (v !== e) begin bad++; $display("FAIL swap_x_reg%0d got=%h exp=%h", i, v, e); end
        end
        restore = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            e = (i == 7) ? 32'h40 : 32'h40 + i;
            read_reg(i, v);
            total++;
            if (v !== e) begin bad++; $display("FAIL swap_y_reg%0d got=%h exp=%h", i, v, e); end
        end
    endtask

    task automatic test_random();
        int v;
        int p;
        int r;
        for (int n = 0; n < 300; n++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_sel = 3'($urandom); wr_data = 8'($urandom);
            pw_en = ($urandom_range(0, 3) == 0); pw_sel = 2'($urandom); pw_data = 16'($urandom);
            id_en = ($urandom_range(0, 2) == 0); id_sel = 2'($urandom); id_dec = 1'($urandom);
            save = ($urandom_range(0, 7) == 0); restore = ($urandom_range(0, 5) == 0);
            cycle();
            total++;
            if (wr_conflict !== m_conf) begin bad++; $display("FAIL rnd_conflict it=%0d got=%b exp=%b", n, wr_conflict, m_conf); end
            total++;
            if (shadow_valid !== m_valid) begin bad++; $display("FAIL rnd_valid it=%0d got=%b exp=%b", n, shadow_valid, m_valid); end
            p = $urandom_range(0, 3);
            read_pair(p, v);
            total++;
            if (v !== m_reg[2*p] * 256 + m_reg[2*p+1]) begin
                bad++; $display("FAIL rnd_pair%0d it=%0d got=%h exp=%h", p, n, v, m_reg[2*p] * 256 + m_reg[2*p+1]);
            end
            r = $urandom_range(0, 7);
            read_reg(r, v);
            total++;
            if (v !== m_reg[r]) begin bad++; $display("FAIL rnd_reg%0d it=%0d got=%h exp=%h", r, n, v, m_reg[r]); end
        end
    endtask

    task automatic test_async_reset();
        pw_en = 1'b1; pw_sel = 2'd1; pw_data = 16'h5AA5;
        wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'h77;
        save = 1'b1; restore = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        total++;
        if (shadow_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", shadow_valid); end
        total++;
        if (wr_conflict !== 1'b0) begin bad++; $display("FAIL arst_conflict got=%b exp=0", wr_conflict); end
        total++;
        if (rd_data !== 24'h0) begin bad++; $display("FAIL arst_rd got=%h exp=0", rd_data); end
        total++;
        if (pr_data !== 16'h0) begin bad++; $display("FAIL arst_pr got=%h exp=0", pr_data); end
        idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_restore_invalid();
        int v;
        restore = 1'b1;
        wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h5A;
        cycle();
        read_reg(1, v);
        total++;
        if (v !== 32'h5A) begin bad++; $display("FAIL rinv_reg1 got=%h exp=5a", v); end
        total++;
        if (wr_conflict !== 1'b0) begin bad++; $display("FAIL rinv_conflict got=%b exp=0", wr_conflict); end
        total++;
        if (shadow_valid !== 1'b0) begin bad++; $display("FAIL rinv_valid got=%b exp=0", shadow_valid); end
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_incdec();
        test_conflict();
        test_flag();
        test_save_restore();
        test_swap();
        test_random();
        test_async_reset();
        test_restore_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
